// File: rtl/posit_link_pkg.sv
// Shared definitions for the posit link host: FSM states, transfer sizes,
// read-slot layout and the write-byte selector.
package posit_link_pkg;

  localparam int unsigned WR_BYTES = 4;
  localparam int unsigned RD_BYTES = 12;

  // Read-slot layout returned by the posit unit
  localparam int unsigned SLOT_ECHO_A_LO = 0;
  localparam int unsigned SLOT_ECHO_A_HI = 1;
  localparam int unsigned SLOT_ECHO_B_LO = 2;
  localparam int unsigned SLOT_ECHO_B_HI = 3;
  localparam int unsigned SLOT_SRE_A     = 4;
  localparam int unsigned SLOT_SRE_B     = 5;
  localparam int unsigned SLOT_MANT_A_LO = 6;
  localparam int unsigned SLOT_MANT_A_HI = 7;
  localparam int unsigned SLOT_MANT_B_LO = 8;
  localparam int unsigned SLOT_MANT_B_HI = 9;
  localparam int unsigned SLOT_POSIT_LO  = 10;
  localparam int unsigned SLOT_POSIT_HI  = 11;

  typedef enum logic [2:0] {
    StIdle,
    StWrWaitRdy,
    StWrWaitTake,
    StRdWaitRdy,
    StRdWaitTake,
    StDone
  } state_e;

  // Write order: a lo, a hi, b lo, b hi
  function automatic logic [7:0] wr_byte(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] idx);
    logic [7:0] r;
    unique case (idx)
      2'd0: r = a[7:0];
      2'd1: r = a[15:8];
      2'd2: r = b[7:0];
      2'd3: r = b[15:8];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/posit_link_if.sv
// Byte link between the host and the posit unit.
//   link_data_o / link_wr_valid_o : host -> unit write byte and strobe
//   link_wr_ready_i               : unit ready to accept a byte
//   link_rd_data_i / link_rd_ready_i : unit -> host byte and availability
//   link_rd_ack_o                 : host acknowledge of a read byte
interface posit_link_if;
  logic [7:0] link_data_o;
  logic       link_wr_valid_o;
  logic       link_wr_ready_i;
  logic       link_rd_ack_o;
  logic       link_rd_ready_i;
  logic [7:0] link_rd_data_i;

  modport master (
    output link_data_o, link_wr_valid_o, link_rd_ack_o,
    input  link_wr_ready_i, link_rd_ready_i, link_rd_data_i
  );

  modport slave (
    input  link_data_o, link_wr_valid_o, link_rd_ack_o,
    output link_wr_ready_i, link_rd_ready_i, link_rd_data_i
  );
endinterface

// File: rtl/link_sync.sv
// Flop-chain synchronizer for a single asynchronous level.
//   clk, rst : clock, synchronous active-high reset (clears the chain)
//   d        : asynchronous input
//   q        : synchronized output, SYNC_STAGES cycles later
// SYNC_STAGES must be at least 2.
module link_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[SYNC_STAGES-2:0], d};
  end

  assign q = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/posit_link_host.sv
// Host side of the posit unit byte link: sends two 16-bit operands as four
// bytes, reads back twelve result bytes and presents them as decoded fields.
//   clk, rst            : clock, synchronous active-high reset
//   start, operand_a/b  : transaction request and operands (taken in idle only)
//   busy, done, timeout_err, echo_mismatch : status
//   res_*               : captured result fields, updated together on done
//   link                : byte link to the posit unit
module posit_link_host
  import posit_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        echo_mismatch,
  output logic [15:0] res_echo_a,
  output logic [15:0] res_echo_b,
  output logic [5:0]  res_sre_a,
  output logic [5:0]  res_sre_b,
  output logic [11:0] res_mant_a,
  output logic [11:0] res_mant_b,
  output logic [15:0] res_posit,
  posit_link_if.master link
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      wr_idx_q, wr_idx_d;
  logic [3:0]      rd_idx_q, rd_idx_d;
  logic [CntW-1:0] tmo_cnt_q;
  logic            tmo_hit, in_wait;
  logic            wr_rdy_s, rd_rdy_s;
  logic [15:0]     op_a_q, op_b_q;
  logic [7:0]      data_q;
  logic            wr_valid_q, rd_ack_q, done_q, timeout_q, mismatch_q;
  logic [7:0]      slot_q [RD_BYTES];
  logic [15:0]     echo_a_w, echo_b_w;
  logic            unused_slot_bits;

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst), .d(link.link_wr_ready_i), .q(wr_rdy_s)
  );
  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst), .d(link.link_rd_ready_i), .q(rd_rdy_s)
  );

  assign echo_a_w = {slot_q[SLOT_ECHO_A_HI], slot_q[SLOT_ECHO_A_LO]};
  assign echo_b_w = {slot_q[SLOT_ECHO_B_HI], slot_q[SLOT_ECHO_B_LO]};
  // Upper bits of the sre/mant-hi slots carry no information
  assign unused_slot_bits = ^{slot_q[SLOT_SRE_A][7:6], slot_q[SLOT_SRE_B][7:6],
                              slot_q[SLOT_MANT_A_HI][7:4], slot_q[SLOT_MANT_B_HI][7:4]};

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    tmo_hit  = 1'b0;
    in_wait  = state_q inside {StWrWaitRdy, StWrWaitTake, StRdWaitRdy, StRdWaitTake};
    unique case (state_q)
      StIdle: if (start) begin
        state_d  = StWrWaitRdy;
        wr_idx_d = '0;
      end
      StWrWaitRdy: if (wr_rdy_s) state_d = StWrWaitTake;
      StWrWaitTake: if (!wr_rdy_s) begin
        if (wr_idx_q == 2'(WR_BYTES - 1)) begin
          rd_idx_d = '0;
          state_d  = StRdWaitRdy;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
          state_d  = StWrWaitRdy;
        end
      end
      StRdWaitRdy: if (rd_rdy_s) state_d = StRdWaitTake;
      StRdWaitTake: if (!rd_rdy_s) begin
        if (rd_idx_q == 4'(RD_BYTES - 1)) begin
          state_d = StDone;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = StRdWaitRdy;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides any progress made in the same cycle
    if (in_wait && tmo_cnt_q == TmoLast) begin
      tmo_hit = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      tmo_cnt_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      data_q     <= '0;
      wr_valid_q <= 1'b0;
      rd_ack_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < RD_BYTES; i++) slot_q[i] <= '0;
      res_echo_a <= '0;
      res_echo_b <= '0;
      res_sre_a  <= '0;
      res_sre_b  <= '0;
      res_mant_a <= '0;
      res_mant_b <= '0;
      res_posit  <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      tmo_cnt_q  <= (state_d != state_q || !in_wait) ? '0 : tmo_cnt_q + 1'b1;
      // Valid/ack are flags of the take states, so they can never overlap
      wr_valid_q <= (state_d == StWrWaitTake);
      rd_ack_q   <= (state_d == StRdWaitTake);
      done_q     <= (state_d == StDone);
      timeout_q  <= tmo_hit;
      if (state_q == StIdle && start) begin
        op_a_q <= operand_a;
        op_b_q <= operand_b;
      end
      if (state_q == StWrWaitRdy && state_d == StWrWaitTake) begin
        data_q <= wr_byte(op_a_q, op_b_q, wr_idx_q);
      end
      if (state_q == StRdWaitRdy && state_d == StRdWaitTake) begin
        slot_q[rd_idx_q] <= link.link_rd_data_i;
      end
      if (state_d == StDone) begin
        res_echo_a <= echo_a_w;
        res_echo_b <= echo_b_w;
        res_sre_a  <= slot_q[SLOT_SRE_A][5:0];
        res_sre_b  <= slot_q[SLOT_SRE_B][5:0];
        res_mant_a <= {slot_q[SLOT_MANT_A_HI][3:0], slot_q[SLOT_MANT_A_LO]};
        res_mant_b <= {slot_q[SLOT_MANT_B_HI][3:0], slot_q[SLOT_MANT_B_LO]};
        res_posit  <= {slot_q[SLOT_POSIT_HI], slot_q[SLOT_POSIT_LO]};
        mismatch_q <= (echo_a_w != op_a_q) || (echo_b_w != op_b_q);
      end
    end
  end

  assign busy                 = (state_q != StIdle);
  assign done                 = done_q;
  assign timeout_err          = timeout_q;
  assign echo_mismatch        = mismatch_q;
  assign link.link_data_o     = data_q;
  assign link.link_wr_valid_o = wr_valid_q;
  assign link.link_rd_ack_o   = rd_ack_q;
endmodule

// File: tb/tb_posit_link_host.sv
module tb_posit_link_host;
  localparam int unsigned TMO = 64;

  typedef struct packed {
    logic [15:0] echo_a;
    logic [15:0] echo_b;
    logic [5:0]  sre_a;
    logic [5:0]  sre_b;
    logic [11:0] mant_a;
    logic [11:0] mant_b;
    logic [15:0] posit;
    logic        mismatch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] operand_a = '0, operand_b = '0;
  logic        busy, done, timeout_err, echo_mismatch;
  logic [15:0] res_echo_a, res_echo_b, res_posit;
  logic [5:0]  res_sre_a, res_sre_b;
  logic [11:0] res_mant_a, res_mant_b;

  posit_link_if lk();

  posit_link_host #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .timeout_err(timeout_err), .echo_mismatch(echo_mismatch),
    .res_echo_a(res_echo_a), .res_echo_b(res_echo_b), .res_sre_a(res_sre_a),
    .res_sre_b(res_sre_b), .res_mant_a(res_mant_a), .res_mant_b(res_mant_b),
    .res_posit(res_posit), .link(lk)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0, done_count = 0, timeout_count = 0, cyc = 0;
  int   t_drop = 0;
  bit   timeout_expected = 1'b0, at_slot6 = 1'b0, last_mismatch = 1'b0;
  exp_t exp_q[$];
  exp_t held = '0;
  exp_t e_dir;
  logic [7:0] resp_bytes [12];
  logic [7:0] exp_wr [4];
  logic [7:0] wr_log [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Poll valid (sel_ack=0) or ack (sel_ack=1) for a level, bounded
  task automatic wait_link(input bit sel_ack, input bit level, input string name,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((sel_ack ? lk.link_rd_ack_o : lk.link_wr_valid_o) == level) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    chk(name, 32'(0), 32'(1));
  endtask

  function automatic exp_t rand_exp(input logic [15:0] a, input logic [15:0] b,
                                    input bit corrupt);
    exp_t e;
    e.echo_a = a;
    e.echo_b = b;
    if (corrupt) begin
      if ($urandom_range(0, 1) == 1) e.echo_a = a ^ 16'(1 << $urandom_range(0, 15));
      else                           e.echo_b = b ^ 16'(1 << $urandom_range(0, 15));
    end
    e.sre_a    = 6'($urandom);
    e.sre_b    = 6'($urandom);
    e.mant_a   = 12'($urandom);
    e.mant_b   = 12'($urandom);
    e.posit    = 16'($urandom);
    e.mismatch = (e.echo_a != a) || (e.echo_b != b);
    return e;
  endfunction

  // Behavioural posit unit: four-phase handshakes with random stall.
  // mode 0 normal, 2 withhold wr_ready for byte 2, 3 stop while slot 6 is acked
  task automatic respond(input int mode);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      if (mode == 2 && i == 2) begin
        for (int k = 0; k < int'(TMO) + 20 && !timeout_err; k++) begin
          @(posedge clk); #1;
        end
        chk("timeout_latency", 32'(cyc - t_drop), 32'(TMO));
        chk("timeout_pulse", 32'(timeout_err), 32'(1));
        chk("timeout_valid", 32'(lk.link_wr_valid_o), 32'(0));
        chk("timeout_busy", 32'(busy), 32'(0));
        return;
      end
      lk.link_wr_ready_i = 1'b1;
      wait_link(1'b0, 1'b1, "wr_valid_rise", ok);
      if (!ok) begin lk.link_wr_ready_i = 1'b0; return; end
      wr_log[i] = lk.link_data_o;
      chk("wr_byte", 32'(lk.link_data_o), 32'(exp_wr[i]));
      idle(int'($urandom_range(0, 3)));
      chk("wr_byte_held", 32'(lk.link_data_o), 32'(exp_wr[i]));
      lk.link_wr_ready_i = 1'b0;
      wait_link(1'b0, 1'b0, "wr_valid_fall", ok);
      if (!ok) return;
      t_drop = cyc;
    end
    for (int i = 0; i < 12; i++) begin
      lk.link_rd_data_i  = resp_bytes[i];
      lk.link_rd_ready_i = 1'b1;
      wait_link(1'b1, 1'b1, "rd_ack_rise", ok);
      if (!ok) begin lk.link_rd_ready_i = 1'b0; return; end
      if (mode == 3 && i == 6) begin
        at_slot6 = 1'b1;
        return;
      end
      idle(int'($urandom_range(0, 3)));
      lk.link_rd_ready_i = 1'b0;
      wait_link(1'b1, 1'b0, "rd_ack_fall", ok);
      if (!ok) return;
      lk.link_rd_data_i = 8'($urandom);
    end
  endtask

  task automatic poke_start();
    bit ok;
    wait_link(1'b1, 1'b1, "poke_wait_read", ok);
    start     = 1'b1;
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    idle(1);
    start = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                         input int mode, input bit poke);
    exp_wr[0] = a[7:0];
    exp_wr[1] = a[15:8];
    exp_wr[2] = b[7:0];
    exp_wr[3] = b[15:8];
    resp_bytes[0]  = e.echo_a[7:0];
    resp_bytes[1]  = e.echo_a[15:8];
    resp_bytes[2]  = e.echo_b[7:0];
    resp_bytes[3]  = e.echo_b[15:8];
    resp_bytes[4]  = {2'($urandom), e.sre_a};
    resp_bytes[5]  = {2'($urandom), e.sre_b};
    resp_bytes[6]  = e.mant_a[7:0];
    resp_bytes[7]  = {4'($urandom), e.mant_a[11:8]};
    resp_bytes[8]  = e.mant_b[7:0];
    resp_bytes[9]  = {4'($urandom), e.mant_b[11:8]};
    resp_bytes[10] = e.posit[7:0];
    resp_bytes[11] = e.posit[15:8];
    if (mode == 0) exp_q.push_back(e);
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    fork
      respond(mode);
      begin
        idle(1);
        start     = 1'b0;
        operand_a = 16'($urandom);
        operand_b = 16'($urandom);
        if (poke) poke_start();
      end
    join
    if (mode != 3) idle(3);
  endtask

  // Compare process: DUT outputs against the scoreboard every cycle
  initial begin
    exp_t ee;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid_ack_exclusive", 32'(lk.link_wr_valid_o & lk.link_rd_ack_o), 32'(0));
        if (timeout_err) begin
          timeout_count++;
          if (!timeout_expected) chk("unexpected_timeout", 32'(1), 32'(0));
        end
        if (done) begin
          done_count++;
          last_mismatch = echo_mismatch;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(1), 32'(0));
          end else begin
            ee   = exp_q.pop_front();
            held = ee;
            chk("echo_mismatch", 32'(echo_mismatch), 32'(ee.mismatch));
          end
        end
        chk("res_echo_a", 32'(res_echo_a), 32'(held.echo_a));
        chk("res_echo_b", 32'(res_echo_b), 32'(held.echo_b));
        chk("res_sre_a", 32'(res_sre_a), 32'(held.sre_a));
        chk("res_sre_b", 32'(res_sre_b), 32'(held.sre_b));
        chk("res_mant_a", 32'(res_mant_a), 32'(held.mant_a));
        chk("res_mant_b", 32'(res_mant_b), 32'(held.mant_b));
        chk("res_posit", 32'(res_posit), 32'(held.posit));
      end
    end
  end

  initial begin
    int dc;
    logic [15:0] ra, rb;
    lk.link_wr_ready_i = 1'b0;
    lk.link_rd_ready_i = 1'b0;
    lk.link_rd_data_i  = '0;
    idle(3);
    rst = 1'b0;
    idle(20);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_valid", 32'(lk.link_wr_valid_o), 32'(0));
    chk("idle_ack", 32'(lk.link_rd_ack_o), 32'(0));
    chk("idle_done", 32'(done), 32'(0));

    // Directed transaction with hand-computed results
    e_dir = '{echo_a: 16'h4000, echo_b: 16'h3800, sre_a: 6'h21, sre_b: 6'h1E,
              mant_a: 12'h800, mant_b: 12'hC00, posit: 16'hABCD, mismatch: 1'b0};
    run_txn(16'h4000, 16'h3800, e_dir, 0, 1'b0);
    chk("dir_done_count", 32'(done_count), 32'(1));
    chk("dir_wr0", 32'(wr_log[0]), 32'(8'h00));
    chk("dir_wr1", 32'(wr_log[1]), 32'(8'h40));
    chk("dir_wr2", 32'(wr_log[2]), 32'(8'h00));
    chk("dir_wr3", 32'(wr_log[3]), 32'(8'h38));
    chk("dir_echo_a", 32'(res_echo_a), 32'(16'h4000));
    chk("dir_sre_a", 32'(res_sre_a), 32'(6'h21));
    chk("dir_sre_b", 32'(res_sre_b), 32'(6'h1E));
    chk("dir_mant_a", 32'(res_mant_a), 32'(12'h800));
    chk("dir_mant_b", 32'(res_mant_b), 32'(12'hC00));
    chk("dir_posit", 32'(res_posit), 32'(16'hABCD));
    chk("dir_mismatch", 32'(last_mismatch), 32'(0));

    // Echo byte 1 returned as 8'h41
    e_dir.echo_a   = 16'h4100;
    e_dir.mismatch = 1'b1;
    run_txn(16'h4000, 16'h3800, e_dir, 0, 1'b0);
    chk("corrupt_done_count", 32'(done_count), 32'(2));
    chk("corrupt_mismatch", 32'(last_mismatch), 32'(1));
    chk("corrupt_echo_a", 32'(res_echo_a), 32'(16'h4100));

    // Unit stalls before byte 2: timeout, no done, results held
    timeout_expected = 1'b1;
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_txn(ra, rb, rand_exp(ra, rb, 1'b0), 2, 1'b0);
    timeout_expected = 1'b0;
    chk("timeout_count", 32'(timeout_count), 32'(1));
    chk("timeout_no_done", 32'(done_count), 32'(2));
    idle(5);

    // Start during read phase is ignored
    dc = done_count;
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_txn(ra, rb, rand_exp(ra, rb, 1'b0), 0, 1'b1);
    idle(5);
    chk("poke_one_done", 32'(done_count), 32'(dc + 1));
    chk("poke_not_busy", 32'(busy), 32'(0));

    // Reset while read slot 6 is acknowledged
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_txn(ra, rb, rand_exp(ra, rb, 1'b0), 3, 1'b0);
    chk("reached_slot6", 32'(at_slot6), 32'(1));
    rst                = 1'b1;
    lk.link_wr_ready_i = 1'b0;
    lk.link_rd_ready_i = 1'b0;
    held               = '0;
    exp_q.delete();
    idle(1);
    chk("rst_ack", 32'(lk.link_rd_ack_o), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_echo_a", 32'(res_echo_a), 32'(0));
    chk("rst_posit", 32'(res_posit), 32'(0));
    chk("rst_mismatch", 32'(echo_mismatch), 32'(0));
    rst = 1'b0;
    idle(3);
    dc = done_count;
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_txn(ra, rb, rand_exp(ra, rb, 1'b0), 0, 1'b0);
    chk("post_rst_done", 32'(done_count), 32'(dc + 1));

    // Randomized transactions, some with corrupted echoes
    dc = done_count;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_txn(ra, rb, rand_exp(ra, rb, $urandom_range(0, 3) == 0), 0, 1'b0);
    end
    chk("rand_done_count", 32'(done_count), 32'(dc + 20));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    chk("timeout_total", 32'(timeout_count), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
